// File: rtl/cis_pattern_sequencer.sv
// CIS/skipper readout sequencer: plays reset, integration and skipping patterns per pixel
// and steps through a pixel cluster with row pulses. Optional abort input: CIS_SEQ_ABORT_EN.
module cis_pattern_sequencer #(
    parameter int NUM_SIGNALS        = 9,
    parameter int PATTERN_LEN        = 12,
    parameter int PIXEL_CLUSTER_SIZE = 16,
    parameter int SKIP_W             = 10,
    parameter int DIV_W              = 10,
    localparam int LEN_W  = $clog2(PATTERN_LEN + 1),
    localparam int NPIX_W = $clog2(PIXEL_CLUSTER_SIZE + 1),
    localparam int PIX_W  = $clog2(PIXEL_CLUSTER_SIZE)
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    integration,
    input  logic                                    global_shutter,
    input  logic [DIV_W-1:0]                        clk_div,
    input  logic [SKIP_W-1:0]                       skip_samples,
    input  logic [NPIX_W-1:0]                       num_pixels,
    input  logic [LEN_W-1:0]                        len_reset,
    input  logic [LEN_W-1:0]                        len_integ,
    input  logic [LEN_W-1:0]                        len_skip,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_ccd_reset,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_integration,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_skipping,
`ifdef CIS_SEQ_ABORT_EN
    input  logic                                    abort,
`endif
    output logic [NUM_SIGNALS-1:0]                  sig_out,
    output logic                                    row_rst,
    output logic                                    row_clk,
    output logic                                    running,
    output logic                                    done,
    output logic [PIX_W-1:0]                        pixel_idx,
    output logic [SKIP_W-1:0]                       skip_idx
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RESET = 3'd2;
    localparam logic [2:0] S_INTEG = 3'd3;
    localparam logic [2:0] S_SKIP  = 3'd4;
    localparam logic [2:0] S_ROW   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state;
    logic              sync1, sync2, sync3, trig;
    logic [DIV_W-1:0]  div_cnt, div_l;
    logic [LEN_W-1:0]  bit_idx, lr_l, li_l, ls_l, cur_len;
    logic [SKIP_W-1:0] skip_cnt, skip_l;
    logic [PIX_W-1:0]  pix_cnt, nlast_l;
    logic              gs_l;
    logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pr_l, pi_l, ps_l;
    logic [NPIX_W-1:0] npix_eff;
    logic [NUM_SIGNALS-1:0] sig_next;
    logic              tick, last_bit, skip_none, more_pix, more_after_row, abort_hit;
    logic [2:0]        post_pix;

    // Out-of-range or zero lengths fall back to the full pattern length.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        if (l == '0 || l > LEN_W'(PATTERN_LEN)) return LEN_W'(PATTERN_LEN);
        return l;
    endfunction

`ifdef CIS_SEQ_ABORT_EN
    assign abort_hit = abort && state != S_IDLE && state != S_DONE;
`else
    assign abort_hit = 1'b0;
`endif

    assign trig           = sync2 & ~sync3;
    assign tick           = (div_cnt == div_l);
    assign npix_eff       = (num_pixels == '0 || num_pixels > NPIX_W'(PIXEL_CLUSTER_SIZE))
                            ? NPIX_W'(PIXEL_CLUSTER_SIZE) : num_pixels;
    assign skip_none      = (skip_l == '0);
    assign more_pix       = (pix_cnt < nlast_l);
    assign more_after_row = ((pix_cnt + PIX_W'(1)) < nlast_l);
    assign post_pix       = more_pix ? S_ROW : S_DONE;
    assign last_bit       = (bit_idx == cur_len - LEN_W'(1));

    always_comb begin
        cur_len  = lr_l;
        sig_next = '0;
        case (state)
            S_INTEG: cur_len = li_l;
            S_SKIP:  cur_len = ls_l;
            default: cur_len = lr_l;
        endcase
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            case (state)
                S_RESET: sig_next[i] = pr_l[i][bit_idx];
                S_INTEG: sig_next[i] = pi_l[i][bit_idx];
                S_SKIP:  sig_next[i] = ps_l[i][bit_idx];
                default: sig_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {sync1, sync2, sync3} <= '0;
        end else begin
            sync1 <= integration;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            skip_cnt <= '0;
            pix_cnt  <= '0;
            div_l    <= '0;
            skip_l   <= '0;
            nlast_l  <= '0;
            lr_l     <= '0;
            li_l     <= '0;
            ls_l     <= '0;
            gs_l     <= 1'b0;
            pr_l     <= '0;
            pi_l     <= '0;
            ps_l     <= '0;
        end else if (abort_hit) begin
            state <= S_DONE;
        end else begin
            case (state)
                S_IDLE: if (trig) begin
                    state    <= S_START;
                    div_cnt  <= '0;
                    bit_idx  <= '0;
                    skip_cnt <= '0;
                    pix_cnt  <= '0;
                    div_l    <= clk_div;
                    skip_l   <= skip_samples;
                    nlast_l  <= PIX_W'(npix_eff - NPIX_W'(1));
                    lr_l     <= eff_len(len_reset);
                    li_l     <= eff_len(len_integ);
                    ls_l     <= eff_len(len_skip);
                    gs_l     <= global_shutter;
                    pr_l     <= pattern_ccd_reset;
                    pi_l     <= pattern_integration;
                    ps_l     <= pattern_skipping;
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) begin
                        bit_idx <= last_bit ? '0 : bit_idx + LEN_W'(1);
                        case (state)
                            S_START: begin
                                state   <= S_RESET;
                                bit_idx <= '0;
                            end
                            S_RESET: if (last_bit) state <= S_INTEG;
                            S_INTEG: if (last_bit) begin
                                state    <= skip_none ? post_pix : S_SKIP;
                                skip_cnt <= '0;
                            end
                            S_SKIP: if (last_bit) begin
                                if (skip_cnt == skip_l - SKIP_W'(1)) begin
                                    skip_cnt <= '0;
                                    state    <= post_pix;
                                end else begin
                                    skip_cnt <= skip_cnt + SKIP_W'(1);
                                end
                            end
                            S_ROW: begin
                                pix_cnt <= pix_cnt + PIX_W'(1);
                                bit_idx <= '0;
                                // Global shutter skips straight to sampling; with no samples only ROW ticks remain.
                                if (!gs_l)          state <= S_RESET;
                                else if (!skip_none) state <= S_SKIP;
                                else                state <= more_after_row ? S_ROW : S_DONE;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_out   <= '0;
            row_rst   <= 1'b0;
            row_clk   <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            pixel_idx <= '0;
            skip_idx  <= '0;
        end else begin
            sig_out   <= abort_hit ? '0 : sig_next;
            row_rst   <= !abort_hit && state == S_START;
            row_clk   <= !abort_hit && state == S_ROW;
            running   <= state != S_IDLE && state != S_DONE;
            done      <= state == S_DONE;
            pixel_idx <= pix_cnt;
            skip_idx  <= skip_cnt;
        end
    end
endmodule

// File: tb/tb_cis_pattern_sequencer.sv
// Directed bench for cis_pattern_sequencer: per-clock comparison of all outputs against
// an expected stream built from the configured patterns, plus reset/retrigger/abort scenarios.
module tb_cis_pattern_sequencer;
    localparam int NS = 9, PL = 12, PCS = 16, SKIP_W = 10, DIV_W = 10;
    localparam int LEN_W = 4, NPIX_W = 5, PIX_W = 4;
    localparam int WW = 4 + NS + PIX_W + SKIP_W;

    logic clk = 1'b0;
    logic reset_n, integration, global_shutter;
    logic [DIV_W-1:0]  clk_div;
    logic [SKIP_W-1:0] skip_samples;
    logic [NPIX_W-1:0] num_pixels;
    logic [LEN_W-1:0]  len_reset, len_integ, len_skip;
    logic [NS-1:0][PL-1:0] pat_reset, pat_integ, pat_skip;
    logic [NS-1:0]     sig_out;
    logic              row_rst, row_clk, running, done;
    logic [PIX_W-1:0]  pixel_idx;
    logic [SKIP_W-1:0] skip_idx;
`ifdef CIS_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [WW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cis_pattern_sequencer dut (
        .clk(clk), .reset_n(reset_n), .integration(integration),
        .global_shutter(global_shutter), .clk_div(clk_div), .skip_samples(skip_samples),
        .num_pixels(num_pixels), .len_reset(len_reset), .len_integ(len_integ),
        .len_skip(len_skip), .pattern_ccd_reset(pat_reset),
        .pattern_integration(pat_integ), .pattern_skipping(pat_skip),
`ifdef CIS_SEQ_ABORT_EN
        .abort(abort),
`endif
        .sig_out(sig_out), .row_rst(row_rst), .row_clk(row_clk), .running(running),
        .done(done), .pixel_idx(pixel_idx), .skip_idx(skip_idx)
    );

    function automatic logic [WW-1:0] mk(input logic r, input logic rr, input logic rc,
                                         input logic d, input logic [NS-1:0] s,
                                         input int p, input int k);
        return {r, rr, rc, d, s, PIX_W'(p), SKIP_W'(k)};
    endfunction

    function automatic logic [NS-1:0] col(input logic [NS-1:0][PL-1:0] pat, input int b);
        logic [NS-1:0] c;
        for (int i = 0; i < NS; i++) c[i] = pat[i][b];
        return c;
    endfunction

    function automatic logic [WW-1:0] observed();
        return {running, row_rst, row_clk, done, sig_out, pixel_idx, skip_idx};
    endfunction

    task automatic push(input logic [WW-1:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w);
    endtask

    // Expected clock-by-clock output stream for the current configuration.
    task automatic build_expected();
        int rep, lr, li, ls, np;
        rep = int'(clk_div) + 1;
        lr = (len_reset == 0 || len_reset > PL) ? PL : int'(len_reset);
        li = (len_integ == 0 || len_integ > PL) ? PL : int'(len_integ);
        ls = (len_skip == 0 || len_skip > PL) ? PL : int'(len_skip);
        np = (num_pixels == 0 || num_pixels > PCS) ? PCS : int'(num_pixels);
        exp_q.delete();
        push(mk(1, 1, 0, 0, '0, 0, 0), rep);
        for (int p = 0; p < np; p++) begin
            if (!global_shutter || p == 0) begin
                for (int b = 0; b < lr; b++) push(mk(1, 0, 0, 0, col(pat_reset, b), p, 0), rep);
                for (int b = 0; b < li; b++) push(mk(1, 0, 0, 0, col(pat_integ, b), p, 0), rep);
            end
            for (int s = 0; s < int'(skip_samples); s++)
                for (int b = 0; b < ls; b++) push(mk(1, 0, 0, 0, col(pat_skip, b), p, s), rep);
            if (p < np - 1) push(mk(1, 0, 1, 0, '0, p, 0), rep);
        end
        push(mk(0, 0, 0, 1, '0, np - 1, 0), 1);
        push(mk(0, 0, 0, 0, '0, np - 1, 0), 2);
    endtask

    task automatic set_defaults();
        global_shutter = 1'b0;
        clk_div        = '0;
        skip_samples   = SKIP_W'(10);
        num_pixels     = NPIX_W'(16);
        len_reset      = LEN_W'(12);
        len_integ      = LEN_W'(12);
        len_skip       = LEN_W'(12);
    endtask

    // cut_kind: 0 full run, 1 async reset at cut_at, 2 abort at cut_at, 3 retrigger/config churn
    task automatic run_check(input string name, input int cut_at, input int cut_kind);
        logic [WW-1:0] got, expv;
        int n;
        build_expected();
        @(negedge clk);
        integration = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (running !== 1'b0 || row_rst !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_early running=%b row_rst=%b expected 0 0", name, running, row_rst);
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 6) integration = 1'b0;
            if (cut_kind == 3) begin
                if (i == 40) integration = 1'b1;
                if (i == 50) integration = 1'b0;
                if (i == 45) begin
                    pat_reset = ~pat_reset;
                    pat_integ = ~pat_integ;
                    pat_skip  = ~pat_skip;
                    skip_samples = SKIP_W'(3);
                    clk_div = DIV_W'(5);
                end
            end
            got  = observed();
            expv = exp_q.pop_front();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL %s stream cycle %0d got=%h expected=%h", name, i, got, expv);
            end
            if (i == cut_at && cut_kind == 1) begin
                #2 reset_n = 1'b0;
                #1 checks++;
                if (observed() !== '0) begin
                    errors++;
                    $display("FAIL %s async_reset_clear got=%h expected=0", name, observed());
                end
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checks++;
                    if (observed() !== '0) begin
                        errors++;
                        $display("FAIL %s held_in_reset got=%h expected=0", name, observed());
                    end
                end
                reset_n = 1'b1;
                repeat (3) @(negedge clk);
                checks++;
                if (done !== 1'b0 || running !== 1'b0) begin
                    errors++;
                    $display("FAIL %s no_done_after_reset done=%b running=%b expected 0 0", name, done, running);
                end
                return;
            end
`ifdef CIS_SEQ_ABORT_EN
            if (i == cut_at && cut_kind == 2) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                checks++;
                if (sig_out !== '0 || row_clk !== 1'b0 || row_rst !== 1'b0 || done !== 1'b0 ||
                    pixel_idx !== PIX_W'(5)) begin
                    errors++;
                    $display("FAIL %s abort_next sig=%h rc=%b rr=%b done=%b pix=%0d expected 0 0 0 0 5",
                             name, sig_out, row_clk, row_rst, done, pixel_idx);
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b1 || running !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_done done=%b running=%b expected 1 0", name, done, running);
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || running !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_idle done=%b running=%b expected 0 0", name, done, running);
                end
                return;
            end
`endif
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        integration = 1'b0;
        set_defaults();
        for (int i = 0; i < NS; i++) begin
            pat_reset[i] = PL'(12'h5A3 ^ (i * 12'h13B));
            pat_integ[i] = PL'(12'hC36 + (i * 12'h0F1));
            pat_skip[i]  = PL'(12'h9E1 ^ (i * 12'h247));
        end
        #1 checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h expected=0", observed());
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h expected=0", observed());
        end
    endtask

    task automatic test_defaults();
        set_defaults();
        run_check("defaults", -1, 0);
    endtask

    task automatic test_clk_div();
        set_defaults();
        clk_div = DIV_W'(3);
        num_pixels = NPIX_W'(1);
        skip_samples = SKIP_W'(2);
        run_check("clk_div", -1, 0);
    endtask

    task automatic test_global_shutter();
        set_defaults();
        global_shutter = 1'b1;
        num_pixels = NPIX_W'(3);
        skip_samples = SKIP_W'(1);
        len_skip = LEN_W'(5);
        run_check("global_shutter", -1, 0);
        global_shutter = 1'b1;
        clk_div = DIV_W'(1);
        skip_samples = '0;
        num_pixels = NPIX_W'(4);
        len_reset = LEN_W'(2);
        len_integ = LEN_W'(1);
        run_check("gs_rows_only", -1, 0);
    endtask

    task automatic test_skip_bypass();
        set_defaults();
        skip_samples = '0;
        len_reset = LEN_W'(4);
        len_integ = LEN_W'(3);
        num_pixels = NPIX_W'(20);
        run_check("skip_bypass", -1, 0);
    endtask

    task automatic test_len_zero();
        set_defaults();
        len_reset = '0;
        len_integ = LEN_W'(13);
        len_skip = '0;
        skip_samples = SKIP_W'(1);
        num_pixels = '0;
        run_check("len_zero", -1, 0);
    endtask

    task automatic test_back_to_back();
        set_defaults();
        run_check("retrigger", -1, 3);
        set_defaults();
        run_check("reset_mid_skip", 100, 1);
        set_defaults();
        clk_div = DIV_W'(1);
        num_pixels = NPIX_W'(2);
        skip_samples = SKIP_W'(2);
        len_skip = LEN_W'(3);
        len_reset = LEN_W'(2);
        len_integ = LEN_W'(2);
        run_check("after_reset", -1, 0);
    endtask

`ifdef CIS_SEQ_ABORT_EN
    task automatic test_abort();
        set_defaults();
        run_check("abort", 800, 2);
    endtask
`endif

    initial begin
        test_reset();
        test_defaults();
        test_clk_div();
        test_global_shutter();
        test_skip_bypass();
        test_len_zero();
        test_back_to_back();
`ifdef CIS_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cis_pattern_sequencer.md
Name: cis_pattern_sequencer

Overview:
Next-generation CIS/skipper readout sequencer. It plays three programmable bit patterns per pixel (reset, integration/transfer, skipping) onto NUM_SIGNALS control lines, and repeats the skipping pattern a programmable number of times. It then advances through a pixel cluster using row-clock pulses. Compared with the previous controller it adds per-phase pattern lengths, a runtime cluster size, a global/rolling shutter mode, config latching and a done strobe. It sits between the slow-control register file and the CIS/SPROCKET pad drivers.

Parameters:
NUM_SIGNALS, 9, number of pattern-driven control lines (PDrst, TG1, TG2, SG, OG, DG, FG_RST, SPROCKET_PED, SPROCKET_SIG)
PATTERN_LEN, 12, maximum pattern length in ticks; bit 0 is played first
PIXEL_CLUSTER_SIZE, 16, maximum pixels per run
SKIP_W, 10, width of skip_samples
DIV_W, 10, width of clk_div

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
integration  in  1  run trigger, asynchronous; a rising edge starts a run
global_shutter  in  1  1 = reset and integration phases only for pixel 0; 0 = every pixel
clk_div  in  DIV_W  tick = clk_div+1 clocks
skip_samples  in  SKIP_W  skip-pattern repetitions per pixel; 0 = skip phase bypassed
num_pixels  in  $clog2(PIXEL_CLUSTER_SIZE+1)  pixels per run; 0 or >PIXEL_CLUSTER_SIZE = PIXEL_CLUSTER_SIZE
len_reset, len_integ, len_skip  in  $clog2(PATTERN_LEN+1) each  active length per phase; 0 or >PATTERN_LEN = PATTERN_LEN
pattern_ccd_reset, pattern_integration, pattern_skipping  in  [NUM_SIGNALS][PATTERN_LEN] each  phase patterns
sig_out  out  NUM_SIGNALS  control lines
row_rst  out  1  row reset pulse
row_clk  out  1  row advance pulse
running  out  1  run in progress
done  out  1  single-clock end-of-run strobe
pixel_idx  out  $clog2(PIXEL_CLUSTER_SIZE)  current pixel
skip_idx  out  SKIP_W  current skip repetition

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counters 0; synchronizer flops 0.
- Trigger path: integration passes through a 2-flop synchronizer and then a rising-edge detect. An edge seen in IDLE starts a run. Edges seen while running are ignored and are not queued.
- At run start, all config inputs and patterns are latched. Changes during a run have no effect until the next run.
- Tick generator: divider counts 0..clk_div, is cleared at run start, and ticks when count==clk_div. clk_div=0 gives a tick every clock.
- States: IDLE -> START -> RESET -> INTEG -> SKIP -> ROW -> (RESET | SKIP | DONE) -> IDLE.
- START lasts one tick with row_rst=1 and sig_out=0.
- RESET: plays pattern_ccd_reset bits 0..len_reset-1, one bit per tick.
- INTEG: plays pattern_integration bits 0..len_integ-1, one bit per tick.
- SKIP: plays pattern_skipping bits 0..len_skip-1 per repetition. skip_idx counts 0..skip_samples-1. With skip_samples=0, SKIP is skipped entirely.
- ROW: one tick with row_clk=1 and sig_out=0. It is entered only if pixel_idx < N-1; pixel_idx then increments.
- After ROW, the next state is RESET if global_shutter=0, else SKIP. With global_shutter=1 and skip_samples=0, a pixel plays nothing and only ROW ticks are emitted.
- The last pixel goes directly to DONE with no ROW tick.
- DONE: one clock with done=1 and running=0; then IDLE.
- Registered outputs: sig_out[i] = latched pattern[i][bit_idx] of the current phase, updated one clock after state/bit_idx change. running rises on the same clock as START's row_rst.
- Latency: integration sampled high at edge k gives row_rst=running=1 from edge k+3.
- Outside RESET, INTEG and SKIP, sig_out=0.
- Phase transitions are gapless: the last bit of one phase is followed by bit 0 of the next on the following tick.
- reset_n asserted mid-run: immediate return to IDLE with all outputs 0. No done strobe.

Optional Feature:
CIS_SEQ_ABORT_EN:
- Defined: adds input abort (1 bit, synchronous). abort=1 in any non-IDLE state forces sig_out=0 and row_clk=row_rst=0 on the next clock, then DONE (done pulses), then IDLE. In IDLE, abort has no effect.
- Undefined: the port is absent and runs always complete.

Test Plan:
1. Defaults: clk_div=0, skip_samples=10, num_pixels=16, lengths=12, global_shutter=0, integration pulse 10 clocks -> running high for 16*(12+12+120)+15+1 = 2320 clocks; 15 row_clk pulses; done once; sig_out[0] sequence matches patterns bit-exact.
2. clk_div=3, num_pixels=1, skip_samples=2, lengths=12 -> every sig_out bit held 4 clocks; no row_clk; running for 4*(1+48) = 196 clocks.
3. global_shutter=1, num_pixels=3, skip_samples=1, len_skip=5 -> RESET/INTEG appear only for pixel 0; pixels 1–2 play only 5-bit skip bursts separated by single row_clk ticks.
4. skip_samples=0, len_reset=4, len_integ=3 -> each pixel is 7 ticks plus ROW; skip_idx stays 0; len=0 inputs behave as 12.
5. Retrigger mid-run and change patterns mid-run -> no restart; output unchanged. Then reset_n=0 mid-SKIP -> all outputs 0 asynchronously; done not pulsed. Next trigger runs normally.
6. With CIS_SEQ_ABORT_EN: abort during pixel 5 SKIP -> sig_out=0 next clock; done pulses one clock later; pixel_idx=5 at abort.
